// File: rtl/nibble_adder_pkg.sv
// Shared definitions for the nibble-serial adder.
//   state_t : controller state encoding (IDLE, RUN, DONE)
//   NIB_W   : bits handled per clock by the adder slice
package nibble_adder_pkg;
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  localparam int NIB_W = 4;
endpackage

// File: rtl/ripple_adder4.sv
// 4-bit ripple-carry adder slice, purely combinational.
// Ports:
//   i_a, i_b : 4-bit addends
//   i_cin    : carry in
//   o_sum    : 4-bit sum
//   o_cout   : carry out of bit 3
module ripple_adder4
  import nibble_adder_pkg::*;
(
  input  logic [NIB_W-1:0] i_a,
  input  logic [NIB_W-1:0] i_b,
  input  logic             i_cin,
  output logic [NIB_W-1:0] o_sum,
  output logic             o_cout
);
  logic [NIB_W:0] w_c;

  assign w_c[0] = i_cin;

  for (genvar gi = 0; gi < NIB_W; gi++) begin : g_fa
    assign o_sum[gi]  = i_a[gi] ^ i_b[gi] ^ w_c[gi];
    assign w_c[gi+1]  = (i_a[gi] & i_b[gi]) | (w_c[gi] & (i_a[gi] ^ i_b[gi]));
  end

  assign o_cout = w_c[NIB_W];
endmodule

// File: rtl/nibble_serial_adder.sv
// Sequential WIDTH-bit adder built from one 4-bit ripple slice, one nibble
// per clock, least-significant nibble first. WIDTH must be a multiple of 4
// and at least 8.
// Ports:
//   clk      : clock, rising edge
//   rst_n    : synchronous active-low reset
//   start    : request an addition, taken only while ready=1
//   a, b     : operands, captured on acceptance
//   cin      : carry into nibble 0, captured on acceptance
//   ready    : can accept start (IDLE or DONE)
//   done     : one-cycle pulse, result valid
//   sum      : result register
//   cout     : carry out of the top nibble
//   overflow : two's-complement overflow
module nibble_serial_adder
  import nibble_adder_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             ready,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             overflow
);
  localparam int NIB = WIDTH / NIB_W;
  localparam int IW  = $clog2(NIB);
  localparam logic [IW-1:0] LAST_IDX = IW'(NIB - 1);

  state_t           r_state;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic             r_c;
  logic [IW-1:0]    r_idx;
  logic [WIDTH-1:0] r_sum;
  logic             r_cout;
  logic             r_ovf;
  logic             r_ready;
  logic             r_done;

  logic [WIDTH-1:0] w_a_sh;
  logic [WIDTH-1:0] w_b_sh;
  logic [NIB_W-1:0] w_a_nib;
  logic [NIB_W-1:0] w_b_nib;
  logic [NIB_W-1:0] w_s;
  logic             w_co;

  // Operand nibble select: shift the current nibble down to bit 0.
  assign w_a_sh  = r_a >> {r_idx, 2'b00};
  assign w_b_sh  = r_b >> {r_idx, 2'b00};
  assign w_a_nib = w_a_sh[NIB_W-1:0];
  assign w_b_nib = w_b_sh[NIB_W-1:0];

  ripple_adder4 u_slice (
    .i_a    (w_a_nib),
    .i_b    (w_b_nib),
    .i_cin  (r_c),
    .o_sum  (w_s),
    .o_cout (w_co)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
      r_a     <= '0;
      r_b     <= '0;
      r_c     <= 1'b0;
      r_idx   <= '0;
      r_sum   <= '0;
      r_cout  <= 1'b0;
      r_ovf   <= 1'b0;
      r_ready <= 1'b1;
      r_done  <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE, ST_DONE: begin
          r_done <= 1'b0;
          if (start) begin
            r_a     <= a;
            r_b     <= b;
            r_c     <= cin;
            r_idx   <= '0;
            r_ready <= 1'b0;
            r_state <= ST_RUN;
          end else begin
            r_ready <= 1'b1;
            r_state <= ST_IDLE;
          end
        end
        ST_RUN: begin
          r_sum[{r_idx, 2'b00} +: NIB_W] <= w_s;
          r_c   <= w_co;
          r_idx <= r_idx + 1'b1;
          if (r_idx == LAST_IDX) begin
            r_cout  <= w_co;
            // Same-sign operands whose result sign differs.
            r_ovf   <= (r_a[WIDTH-1] == r_b[WIDTH-1]) && (w_s[NIB_W-1] != r_a[WIDTH-1]);
            r_ready <= 1'b1;
            r_done  <= 1'b1;
            r_state <= ST_DONE;
          end
        end
        default: begin
          r_ready <= 1'b1;
          r_done  <= 1'b0;
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  assign ready    = r_ready;
  assign done     = r_done;
  assign sum      = r_sum;
  assign cout     = r_cout;
  assign overflow = r_ovf;
endmodule

// File: tb/tb_nibble_serial_adder.sv
module tb_nibble_serial_adder;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n;

  // WIDTH=16 instance
  logic        start16, cin16;
  logic [15:0] a16, b16, sum16;
  logic        ready16, done16, cout16, ovf16;

  // WIDTH=8 instance
  logic        start8, cin8;
  logic [7:0]  a8, b8, sum8;
  logic        ready8, done8, cout8, ovf8;

  // WIDTH=32 instance
  logic        start32, cin32;
  logic [31:0] a32, b32, sum32;
  logic        ready32, done32, cout32, ovf32;

  nibble_serial_adder #(.WIDTH(16)) dut16 (
    .clk(clk), .rst_n(rst_n), .start(start16), .a(a16), .b(b16), .cin(cin16),
    .ready(ready16), .done(done16), .sum(sum16), .cout(cout16), .overflow(ovf16));

  nibble_serial_adder #(.WIDTH(8)) dut8 (
    .clk(clk), .rst_n(rst_n), .start(start8), .a(a8), .b(b8), .cin(cin8),
    .ready(ready8), .done(done8), .sum(sum8), .cout(cout8), .overflow(ovf8));

  nibble_serial_adder #(.WIDTH(32)) dut32 (
    .clk(clk), .rst_n(rst_n), .start(start32), .a(a32), .b(b32), .cin(cin32),
    .ready(ready32), .done(done32), .sum(sum32), .cout(cout32), .overflow(ovf32));

  int tests = 0;
  int fails = 0;

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  typedef struct {
    logic [15:0] a;
    logic [15:0] b;
    logic        cin;
    logic [15:0] exp_sum;
    logic        exp_cout;
    logic        exp_ovf;
  } vec_t;

  vec_t vecs[9];

  // Starts an op on dut16 at a negedge in IDLE; returns done latency in
  // cycles (negedges after acceptance) and number of those cycles with ready low.
  task automatic run16(input logic [15:0] av, input logic [15:0] bv, input logic c,
                       output int lat, output int rdy_low);
    a16 = av; b16 = bv; cin16 = c; start16 = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start16 = 1'b0;
    lat = 1; rdy_low = 0;
    while (!done16 && lat < 20) begin
      if (!ready16) rdy_low++;
      @(negedge clk);
      lat++;
    end
  endtask

  int lat, rl, ndone;
  logic [63:0] ref64;
  logic        rovf;

  initial begin
    vecs[0] = '{16'h0003, 16'h000C, 1'b0, 16'h000F, 1'b0, 1'b0};
    vecs[1] = '{16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0};
    vecs[2] = '{16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b1};
    vecs[3] = '{16'h8000, 16'h8000, 1'b0, 16'h0000, 1'b1, 1'b1};
    vecs[4] = '{16'h1234, 16'h4321, 1'b1, 16'h5556, 1'b0, 1'b0};
    vecs[5] = '{16'hFFFF, 16'hFFFF, 1'b1, 16'hFFFF, 1'b1, 1'b0};
    vecs[6] = '{16'h8000, 16'hFFFF, 1'b0, 16'h7FFF, 1'b1, 1'b1};
    vecs[7] = '{16'h0F0F, 16'h00F1, 1'b0, 16'h1000, 1'b0, 1'b0};
    vecs[8] = '{16'h4000, 16'h4000, 1'b0, 16'h8000, 1'b0, 1'b1};

    rst_n = 1'b0;
    start16 = 0; a16 = 0; b16 = 0; cin16 = 0;
    start8 = 0;  a8 = 0;  b8 = 0;  cin8 = 0;
    start32 = 0; a32 = 0; b32 = 0; cin32 = 0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    chk("reset_ready", ready16, 1);
    chk("reset_done", done16, 0);
    chk("reset_sum", sum16, 0);
    chk("reset_cout", cout16, 0);
    chk("reset_ovf", ovf16, 0);

    // Table-driven vectors
    foreach (vecs[i]) begin
      run16(vecs[i].a, vecs[i].b, vecs[i].cin, lat, rl);
      chk($sformatf("v%0d_latency", i), lat, 5);
      chk($sformatf("v%0d_ready_low", i), rl, 4);
      chk($sformatf("v%0d_sum", i), sum16, vecs[i].exp_sum);
      chk($sformatf("v%0d_cout", i), cout16, vecs[i].exp_cout);
      chk($sformatf("v%0d_ovf", i), ovf16, vecs[i].exp_ovf);
      @(negedge clk);
      chk($sformatf("v%0d_done_pulse", i), done16, 0);
      chk($sformatf("v%0d_ready_idle", i), ready16, 1);
      repeat (2) @(negedge clk);
      chk($sformatf("v%0d_sum_hold", i), sum16, vecs[i].exp_sum);
    end

    // Operand changes and start pulses during RUN are ignored
    a16 = 16'h1234; b16 = 16'h4321; cin16 = 1'b1; start16 = 1'b1;
    @(posedge clk);
    @(negedge clk);
    a16 = 16'hFFFF; b16 = 16'hFFFF; cin16 = 1'b0;
    ndone = 0; lat = 1;
    while (!done16 && lat < 20) begin
      start16 = ~start16;
      @(negedge clk);
      lat++;
    end
    if (done16) ndone++;
    chk("run_ignore_latency", lat, 5);
    chk("run_ignore_sum", sum16, 16'h5556);
    // Back-to-back: start in the DONE cycle
    a16 = 16'h0001; b16 = 16'h0001; cin16 = 1'b0; start16 = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start16 = 1'b0;
    lat = 1;
    while (!done16 && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    if (done16) ndone++;
    chk("b2b_done_count", ndone, 2);
    chk("b2b_latency", lat, 5);
    chk("b2b_sum", sum16, 16'h0002);
    @(negedge clk);

    // Make outputs nonzero first so the reset clearing is observable
    run16(16'hFFFF, 16'h8001, 1'b0, lat, rl);
    chk("pre_rst_sum", sum16, 16'h8000);
    chk("pre_rst_cout", cout16, 1);
    @(negedge clk);
    a16 = 16'h1111; b16 = 16'h2222; cin16 = 1'b0; start16 = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start16 = 1'b0;
    @(negedge clk);
    rst_n = 1'b0;
    start16 = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    start16 = 1'b0;
    chk("midrst_sum", sum16, 0);
    chk("midrst_cout", cout16, 0);
    chk("midrst_ovf", ovf16, 0);
    chk("midrst_ready", ready16, 1);
    ndone = 0;
    repeat (8) begin
      if (done16) ndone++;
      @(negedge clk);
    end
    chk("midrst_no_done", ndone, 0);
    run16(16'h00FF, 16'h0001, 1'b0, lat, rl);
    chk("post_rst_latency", lat, 5);
    chk("post_rst_sum", sum16, 16'h0100);
    chk("post_rst_cout", cout16, 0);

    // Random sweep, WIDTH=8
    for (int i = 0; i < 1000; i++) begin
      a8 = 8'($urandom); b8 = 8'($urandom); cin8 = 1'($urandom);
      ref64 = 64'(a8) + 64'(b8) + 64'(cin8);
      rovf = (a8[7] == b8[7]) && (ref64[7] != a8[7]);
      start8 = 1'b1;
      @(posedge clk);
      @(negedge clk);
      start8 = 1'b0;
      lat = 1;
      while (!done8 && lat < 20) begin
        @(negedge clk);
        lat++;
      end
      chk("rand8_latency", lat, 3);
      chk("rand8_result", {cout8, sum8}, ref64[8:0]);
      chk("rand8_ovf", ovf8, rovf);
    end

    // Random sweep, WIDTH=32
    for (int i = 0; i < 1000; i++) begin
      a32 = $urandom; b32 = $urandom; cin32 = 1'($urandom);
      if (i == 0) begin a32 = 32'hFFFF_FFFF; b32 = 32'h0; cin32 = 1'b1; end
      ref64 = 64'(a32) + 64'(b32) + 64'(cin32);
      rovf = (a32[31] == b32[31]) && (ref64[31] != a32[31]);
      start32 = 1'b1;
      @(posedge clk);
      @(negedge clk);
      start32 = 1'b0;
      lat = 1;
      while (!done32 && lat < 30) begin
        @(negedge clk);
        lat++;
      end
      chk("rand32_latency", lat, 9);
      chk("rand32_result", {cout32, sum32}, ref64[32:0]);
      chk("rand32_ovf", ovf32, rovf);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
